// File: rtl/mac_array.sv
// mac_array: LANES parallel multiply-accumulate lanes with a broadcast B
// operand. The pipeline has three stages: input capture, product, then
// accumulate with optional saturation. Each lane has a sticky overflow flag.
// done marks the cycle in which acc_out holds a completed group.
module mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            clr,
  input  logic                            last,
  input  logic [LANES*DATA_WIDTH-1:0]     a_in,
  input  logic [DATA_WIDTH-1:0]           b_in,
  output logic [LANES*ACC_WIDTH-1:0]      acc_out,
  output logic [LANES-1:0]                ovf,
  output logic                            done,
  output logic                            busy
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int EXT = ACC_WIDTH - PW;

  // Stage-1 registers: raw operands and controls.
  logic [LANES*DATA_WIDTH-1:0] r_a1;
  logic [DATA_WIDTH-1:0]       r_b1;
  logic                        r_en1, r_clr1, r_last1;

  // Stage-2 controls, delayed alongside the product.
  logic                        r_en2, r_clr2, r_last2;
  logic                        r_done;

  // Widened broadcast operand. The fill bit is the sign only in signed mode.
  logic [PW-1:0]               w_bx;

  assign w_bx = {{DATA_WIDTH{r_b1[DATA_WIDTH-1] & SIGNED}}, r_b1};

  // Stage 1: capture operands and controls.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // in a clocked block samples its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1    <= '0;
      r_b1    <= '0;
      r_en1   <= 1'b0;
      r_clr1  <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_a1    <= a_in;
      r_b1    <= b_in;
      r_en1   <= en;
      r_clr1  <= clr;
      r_last1 <= last;
    end
  end

  // Stage 2 controls, and the registered done that stage 3 produces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en2   <= 1'b0;
      r_clr2  <= 1'b0;
      r_last2 <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_en2   <= r_en1;
      r_clr2  <= r_clr1;
      r_last2 <= r_last1;
      r_done  <= r_en2 & r_last2;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_a;
    logic [PW-1:0]         w_ax;
    logic [PW-1:0]         w_prod;
    logic [PW-1:0]         r_prod;
    logic [ACC_WIDTH-1:0]  w_ext;
    logic [ACC_WIDTH:0]    w_sum;
    logic [ACC_WIDTH-1:0]  w_sat;
    logic                  w_ovf;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_ovf;

    // Both operands are extended to the product width first. The low PW
    // bits of the product are then correct for either signedness.
    assign w_a    = r_a1[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_ax   = {{DATA_WIDTH{w_a[DATA_WIDTH-1] & SIGNED}}, w_a};
    assign w_prod = w_ax * w_bx;

    if (EXT > 0) begin : g_ext
      assign w_ext = {{EXT{r_prod[PW-1] & SIGNED}}, r_prod};
    end else begin : g_noext
      assign w_ext = r_prod;
    end

    // The sum is one bit wider than the accumulator. In unsigned mode that
    // extra bit is the carry out.
    assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_ovf = SIGNED ? ((r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                             (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
                          : w_sum[ACC_WIDTH];
    // A signed overflow takes the direction of the operands' shared sign.
    assign w_sat = !SIGNED             ? {ACC_WIDTH{1'b1}} :
                   r_acc[ACC_WIDTH-1]  ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                         {1'b0, {(ACC_WIDTH-1){1'b1}}};

    // Stage 2: register the lane product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prod <= '0;
      else        r_prod <= w_prod;
    end

    // Stage 3: clear-and-start, clear, accumulate, or hold, in that priority.
    // NOTE: accumulators are ordinary flops, so reset clears them. They are
    // not a RAM, and no reset-less inference is wanted here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_clr2 && r_en2) begin
        r_acc <= w_ext;
        r_ovf <= 1'b0;
      end else if (r_clr2) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_en2) begin
        r_acc <= (w_ovf && SATURATE) ? w_sat : w_sum[ACC_WIDTH-1:0];
        if (w_ovf) r_ovf <= 1'b1;
      end
    end

    assign acc_out[gi*ACC_WIDTH +: ACC_WIDTH] = r_acc;
    assign ovf[gi]                            = r_ovf;
  end

  assign done = r_done;
  assign busy = r_en1 | r_en2;

endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: a directed-vector scoreboard bench for mac_array.
// Four instances cover these configurations: the default, unsigned 16-bit
// saturating, signed 16-bit saturating, and signed 16-bit wrapping.
// The driver pushes the hand-computed result of each beat. The monitor pops
// that result three edges later and compares it against the DUT outputs.
module tb_mac_array;

  typedef struct packed {
    logic [1:0]       inst;
    logic             done;
    logic [7:0]       ovf;
    logic [7:0][63:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0][7:0] a_in = '0;
  logic [7:0]      b_in = '0;
  logic            last = 1'b0;
  logic [3:0]      en_v = '0;
  logic [3:0]      clr_v = '0;
  logic [3:0]      issue = '0;

  logic [191:0] acc0;
  logic [127:0] acc1, acc2, acc3;
  logic [191:0] acc_w [4];
  logic [7:0]   ovf_w [4];
  logic [3:0]   done_w, busy_w;

  exp_t       sb_q[$];
  logic [2:0] sr [4];
  int         n_checks = 0;
  int         n_err = 0;

  localparam int ACCW [4] = '{24, 16, 16, 16};
  localparam bit SGN  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  mac_array #(.DATA_WIDTH(8), .LANES(8), .ACC_WIDTH(24), .SIGNED(1'b0), .SATURATE(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .clr(clr_v[0]), .last(last), .a_in(a_in),
    .b_in(b_in), .acc_out(acc0), .ovf(ovf_w[0]), .done(done_w[0]), .busy(busy_w[0]));
  mac_array #(.DATA_WIDTH(8), .LANES(8), .ACC_WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .clr(clr_v[1]), .last(last), .a_in(a_in),
    .b_in(b_in), .acc_out(acc1), .ovf(ovf_w[1]), .done(done_w[1]), .busy(busy_w[1]));
  mac_array #(.DATA_WIDTH(8), .LANES(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .clr(clr_v[2]), .last(last), .a_in(a_in),
    .b_in(b_in), .acc_out(acc2), .ovf(ovf_w[2]), .done(done_w[2]), .busy(busy_w[2]));
  mac_array #(.DATA_WIDTH(8), .LANES(8), .ACC_WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en_v[3]), .clr(clr_v[3]), .last(last), .a_in(a_in),
    .b_in(b_in), .acc_out(acc3), .ovf(ovf_w[3]), .done(done_w[3]), .busy(busy_w[3]));

  assign acc_w[0] = acc0;
  assign acc_w[1] = {64'b0, acc1};
  assign acc_w[2] = {64'b0, acc2};
  assign acc_w[3] = {64'b0, acc3};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm,
               $signed(act), act, $signed(req), req);
    end
  endtask

  // Extract one lane and widen it to 64 bits, sign-extending signed lanes.
  function automatic logic [63:0] lane_val(input logic [191:0] v, input int idx,
                                           input int w, input bit s);
    logic [63:0] x;
    x = '0;
    for (int b = 0; b < w; b++) x[b] = v[idx*w + b];
    if (s && x[w-1]) for (int b = w; b < 64; b++) x[b] = 1'b1;
    return x;
  endfunction

  function automatic logic [7:0][7:0] uni_a(input logic [7:0] v);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [7:0][63:0] uni_e(input longint v);
    logic [7:0][63:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  // Drive one beat into one instance. When push is set, also queue the
  // beat's expected result.
  task automatic beat(input int inst, input logic [7:0][7:0] a, input logic [7:0] b,
                      input bit e, input bit c, input bit l,
                      input logic [7:0][63:0] ea, input logic [7:0] eo, input bit push);
    exp_t x;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    last  = l;
    en_v  = '0;
    clr_v = '0;
    issue = '0;
    en_v[inst]  = e;
    clr_v[inst] = c;
    if (push) begin
      issue[inst] = 1'b1;
      x.inst = 2'(inst);
      x.done = e & l;
      x.ovf  = eo;
      x.acc  = ea;
      sb_q.push_back(x);
    end
  endtask

  task automatic idle(input bit l);
    @(negedge clk);
    en_v  = '0;
    clr_v = '0;
    issue = '0;
    last  = l;
  endtask

  // Monitor: runs 1 time unit after each rising edge. A beat issued at edge
  // k is popped here after edge k+2. On every other cycle, done must be low.
  always @(posedge clk) begin
    exp_t x;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) sr[i] = '0;
      else        sr[i] = {sr[i][1:0], issue[i]};
      if (sr[i][2]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow inst%0d: got empty queue expected an entry", i);
        end else begin
          x = sb_q.pop_front();
          check($sformatf("sb_inst%0d", i), 64'(i), 64'(x.inst));
          for (int j = 0; j < 8; j++)
            check($sformatf("acc_i%0d_l%0d", i, j), lane_val(acc_w[i], j, ACCW[i], SGN[i]), x.acc[j]);
          check($sformatf("ovf_i%0d", i), 64'(ovf_w[i]), 64'(x.ovf));
          check($sformatf("done_i%0d", i), 64'(done_w[i]), 64'(x.done));
        end
      end else begin
        check($sformatf("done_idle_i%0d", i), 64'(done_w[i]), 64'd0);
      end
    end
  end

  initial begin
    logic [7:0][7:0] a_mix;
    logic [7:0][63:0] e_mix;

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_acc_i%0d", i), acc_w[i][63:0], 64'd0);
      check($sformatf("rst_ovf_i%0d", i), 64'(ovf_w[i]), 64'd0);
    end
    check("rst_done", 64'(done_w), 64'd0);
    check("rst_busy", 64'(busy_w), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: four back-to-back beats of 3*5, with last on beat 4
    beat(0, uni_a(8'd3), 8'd5, 1, 0, 0, uni_e(15), 8'h00, 1);
    beat(0, uni_a(8'd3), 8'd5, 1, 0, 0, uni_e(30), 8'h00, 1);
    beat(0, uni_a(8'd3), 8'd5, 1, 0, 0, uni_e(45), 8'h00, 1);
    beat(0, uni_a(8'd3), 8'd5, 1, 0, 1, uni_e(60), 8'h00, 1);
    idle(0);
    check("busy_inflight", 64'(busy_w[0]), 64'd1);
    repeat (2) idle(0);
    check("busy_after", 64'(busy_w[0]), 64'd0);

    // Test 2: clear, accumulate 10, clear-and-start 16, clear
    beat(0, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    beat(0, uni_a(8'd2), 8'd5, 1, 0, 0, uni_e(10), 8'h00, 1);
    beat(0, uni_a(8'd4), 8'd4, 1, 1, 0, uni_e(16), 8'h00, 1);
    beat(0, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    idle(1);   // last without en must not produce done
    repeat (4) idle(0);

    // Test 3: unsigned saturation on 16 bits
    beat(1, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    beat(1, uni_a(8'd255), 8'd255, 1, 0, 0, uni_e(65025), 8'h00, 1);
    beat(1, uni_a(8'd255), 8'd255, 1, 0, 0, uni_e(65535), 8'hFF, 1);
    beat(1, uni_a(8'd255), 8'd255, 1, 0, 1, uni_e(65535), 8'hFF, 1);
    beat(1, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    // Only lane 0 overflows
    a_mix = uni_a(8'd1);
    a_mix[0] = 8'd255;
    e_mix = uni_e(255);
    e_mix[0] = 64'd65025;
    beat(1, a_mix, 8'd255, 1, 0, 0, e_mix, 8'h00, 1);
    e_mix = uni_e(510);
    e_mix[0] = 64'd65535;
    beat(1, a_mix, 8'd255, 1, 0, 0, e_mix, 8'h01, 1);
    repeat (4) idle(0);

    // Test 4: signed, -128*127 three times, then +1. Saturating instance.
    beat(2, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    beat(2, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(-16256), 8'h00, 1);
    beat(2, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(-32512), 8'h00, 1);
    beat(2, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(-32768), 8'hFF, 1);
    beat(2, uni_a(8'd1), 8'd1, 1, 0, 0, uni_e(-32767), 8'hFF, 1);
    // Positive overflow clamps to the maximum
    beat(2, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    beat(2, uni_a(8'd127), 8'd127, 1, 0, 0, uni_e(16129), 8'h00, 1);
    beat(2, uni_a(8'd127), 8'd127, 1, 0, 0, uni_e(32258), 8'h00, 1);
    beat(2, uni_a(8'd127), 8'd127, 1, 0, 0, uni_e(32767), 8'hFF, 1);
    repeat (4) idle(0);
    // Same negative sequence on the wrapping instance
    beat(3, uni_a(8'd0), 8'd0, 0, 1, 0, uni_e(0), 8'h00, 1);
    beat(3, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(-16256), 8'h00, 1);
    beat(3, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(-32512), 8'h00, 1);
    beat(3, uni_a(8'h80), 8'd127, 1, 0, 0, uni_e(16768), 8'hFF, 1);
    beat(3, uni_a(8'd1), 8'd1, 1, 0, 0, uni_e(16769), 8'hFF, 1);
    repeat (4) idle(0);

    // Test 5: per-lane a_i = i, b = -1. Clear-and-start with last.
    for (int i = 0; i < 8; i++) begin
      a_mix[i] = 8'(i);
      e_mix[i] = -64'(i);
    end
    beat(2, a_mix, 8'hFF, 1, 1, 1, e_mix, 8'h00, 1);
    repeat (4) idle(0);

    // Test 6: reset while a last beat is in flight
    beat(0, uni_a(8'd1), 8'd7, 1, 0, 0, uni_e(7), 8'h00, 1);
    beat(0, uni_a(8'd1), 8'd1, 1, 0, 0, uni_e(8), 8'h00, 1);
    repeat (4) idle(0);
    beat(0, uni_a(8'd1), 8'd1, 1, 0, 1, uni_e(0), 8'h00, 0);
    idle(0);
    rst_n = 1'b0;
    #1;
    check("midrst_acc", acc_w[0][63:0], 64'd0);
    check("midrst_ovf", 64'(ovf_w[0]), 64'd0);
    check("midrst_done", 64'(done_w[0]), 64'd0);
    check("midrst_busy", 64'(busy_w[0]), 64'd0);
    repeat (2) idle(0);
    rst_n = 1'b1;
    beat(0, uni_a(8'd2), 8'd3, 1, 0, 0, uni_e(6), 8'h00, 1);
    beat(0, uni_a(8'd2), 8'd3, 1, 0, 1, uni_e(12), 8'h00, 1);

    // Drain the scoreboard, bounded
    for (int t = 0; t < 20 && sb_q.size() > 0; t++) idle(0);
    repeat (2) idle(0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
